// File: rtl/vp_fb_writer_if.sv
// -----------------------------------------------------------------------------
// vp_fb_writer_if
//
// Purpose:
//   Bundles the two handshakes of the frame-buffer writer into one interface:
//   the pull side towards the upstream video-processing output FIFO and the
//   push side towards frame-buffer memory.
//
// Signals:
//   data_ready  writer -> FIFO    one-cycle read tick
//   data_valid  FIFO   -> writer  FIFO holds at least one pixel
//   data        FIFO   -> writer  read data, valid the cycle after the tick
//   mem_wr      writer -> memory  write request, held until accepted
//   mem_ready   memory -> writer  write accepted when mem_wr & mem_ready
//   mem_addr    writer -> memory  write address
//   mem_data    writer -> memory  write data
//
// Modports:
//   master  used by vp_fb_writer
//   slave   used by the FIFO/memory side (or a testbench standing in for it)
// -----------------------------------------------------------------------------
interface vp_fb_writer_if #(
    parameter int DW = 12,
    parameter int AW = 20
);
    logic          data_ready;
    logic          data_valid;
    logic [DW-1:0] data;
    logic          mem_wr;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;

    modport master (
        output data_ready,
        input  data_valid,
        input  data,
        output mem_wr,
        input  mem_ready,
        output mem_addr,
        output mem_data
    );

    modport slave (
        input  data_ready,
        output data_valid,
        output data,
        input  mem_wr,
        output mem_ready,
        input  mem_addr,
        input  mem_data
    );
endinterface

// File: rtl/vp_fb_writer.sv
// -----------------------------------------------------------------------------
// vp_fb_writer
//
// Purpose:
//   Pulls filtered pixels one at a time from the upstream FIFO, tracks the
//   raster position (x, y) and writes each pixel to frame-buffer memory at
//   base + y*RL + x. Pulses o_frame_done after the last pixel of a frame has
//   been accepted by memory.
//
// Optional feature (compile-time macro VP_FB_DOUBLE_BUF_EN):
//   Defined   : ping-pong between two frame buffers. o_wr_buf toggles at each
//               frame done and o_rd_buf takes the buffer just completed.
//               Addresses span 0 .. 2*RL*NL-1.
//   Undefined : single buffer, o_wr_buf = o_rd_buf = 0, addresses span
//               0 .. RL*NL-1.
//
// Parameters:
//   DW  pixel data width
//   RL  pixels per line
//   NL  lines per frame
//   AW  memory address width (must hold 2*RL*NL-1)
//
// Ports:
//   i_clk          clock
//   i_rstn         synchronous active-low reset
//   i_enable       1 = fetch pixels; 0 = stay idle once the current pixel ends
//   i_frame_start  one-cycle pulse: realign raster counters to pixel 0
//   bus            FIFO read handshake + memory write handshake (master side)
//   o_frame_done   one-cycle pulse after the last pixel of a frame is accepted
//   o_wr_buf       buffer currently being written
//   o_rd_buf       buffer holding the last complete frame
//
// Per-pixel sequence (minimum 4 cycles):
//   IDLE -> RD (read tick) -> LATCH (capture FIFO data) -> WR (until accepted)
// -----------------------------------------------------------------------------
module vp_fb_writer #(
    parameter int DW = 12,
    parameter int RL = 640,
    parameter int NL = 480,
    parameter int AW = 20
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_enable,
    input  logic            i_frame_start,
    vp_fb_writer_if.master  bus,
    output logic            o_frame_done,
    output logic            o_wr_buf,
    output logic            o_rd_buf
);

    localparam int XW = (RL > 1) ? $clog2(RL) : 1;
    localparam int YW = (NL > 1) ? $clog2(NL) : 1;

    // Size of one frame in pixels; also the base of the second buffer.
    localparam logic [AW-1:0] FRAME_PIX = AW'(RL * NL);
    localparam logic [XW-1:0] X_LAST    = XW'(RL - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(NL - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RD    = 2'd1,
        S_LATCH = 2'd2,
        S_WR    = 2'd3
    } state_t;

    state_t        state_q,      state_d;
    logic [XW-1:0] x_q,          x_d;
    logic [YW-1:0] y_q,          y_d;
    logic [AW-1:0] lin_q,        lin_d;
    logic          pend_q,       pend_d;
    logic          data_ready_q, data_ready_d;
    logic          mem_wr_q,     mem_wr_d;
    logic [AW-1:0] mem_addr_q,   mem_addr_d;
    logic [DW-1:0] mem_data_q,   mem_data_d;
    logic          frame_done_q, frame_done_d;
    logic          wr_buf_q,     wr_buf_d;
    logic          rd_buf_q,     rd_buf_d;

    logic [AW-1:0] base;
    logic          last_x;
    logic          last_y;

    // Base address of the buffer being written.
    always_comb begin
`ifdef VP_FB_DOUBLE_BUF_EN
        base = wr_buf_q ? FRAME_PIX : '0;
`else
        base = '0;
`endif
    end

    assign last_x = (x_q == X_LAST);
    assign last_y = (y_q == Y_LAST);

    // -------------------------------------------------------------------------
    // Next-state logic. Every output is a flop, so the read tick is decided in
    // IDLE and is high exactly while the FSM sits in RD.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        lin_d        = lin_q;
        mem_wr_d     = mem_wr_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        wr_buf_d     = wr_buf_q;
        rd_buf_d     = rd_buf_q;
        data_ready_d = 1'b0;
        frame_done_d = 1'b0;
        // A frame-start is remembered from any state and only consumed in IDLE,
        // so an in-flight pixel still lands at its original address.
        pend_d       = pend_q | i_frame_start;

        unique case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    // Realign costs one idle cycle. A new pulse arriving in
                    // this very cycle stays pending.
                    x_d    = '0;
                    y_d    = '0;
                    lin_d  = '0;
                    pend_d = i_frame_start;
                end else if (i_enable && bus.data_valid) begin
                    data_ready_d = 1'b1;
                    state_d      = S_RD;
                end
            end

            S_RD: begin
                // FIFO read data appears on bus.data during LATCH; valid is
                // no longer looked at for this pixel.
                state_d = S_LATCH;
            end

            S_LATCH: begin
                mem_data_d = bus.data;
                mem_addr_d = base + lin_q;
                mem_wr_d   = 1'b1;
                state_d    = S_WR;
            end

            S_WR: begin
                if (bus.mem_ready) begin
                    mem_wr_d = 1'b0;
                    state_d  = S_IDLE;
                    if (last_x) begin
                        x_d = '0;
                        if (last_y) begin
                            y_d          = '0;
                            lin_d        = '0;
                            frame_done_d = 1'b1;
`ifdef VP_FB_DOUBLE_BUF_EN
                            wr_buf_d     = ~wr_buf_q;
                            rd_buf_d     = wr_buf_q;
`endif
                        end else begin
                            y_d   = y_q + 1'b1;
                            lin_d = lin_q + 1'b1;
                        end
                    end else begin
                        x_d   = x_q + 1'b1;
                        lin_d = lin_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers. Reset drops any pixel in flight.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            lin_q        <= '0;
            pend_q       <= 1'b0;
            data_ready_q <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            frame_done_q <= 1'b0;
            wr_buf_q     <= 1'b0;
            rd_buf_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            lin_q        <= lin_d;
            pend_q       <= pend_d;
            data_ready_q <= data_ready_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            frame_done_q <= frame_done_d;
            wr_buf_q     <= wr_buf_d;
            rd_buf_q     <= rd_buf_d;
        end
    end

    assign bus.data_ready = data_ready_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_data   = mem_data_q;
    assign o_frame_done   = frame_done_q;
    assign o_wr_buf       = wr_buf_q;
    assign o_rd_buf       = rd_buf_q;

endmodule

// File: tb/tb_vp_fb_writer.sv
// -----------------------------------------------------------------------------
// tb_vp_fb_writer
//
// Directed bench for vp_fb_writer with RL=4, NL=2 (8-pixel frames). Covers
// reset, streaming, memory backpressure, mid-frame realign, buffer selection
// (either build of VP_FB_DOUBLE_BUF_EN), i_enable gating and reset in the
// middle of a pixel.
// -----------------------------------------------------------------------------
module tb_vp_fb_writer;

    localparam int DW = 12;
    localparam int RL = 4;
    localparam int NL = 2;
    localparam int AW = 5;

`ifdef VP_FB_DOUBLE_BUF_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    // Base of the second frame written after reset.
    localparam logic [AW-1:0] B2 = DB ? 5'd8 : 5'd0;

    logic clk = 1'b0;
    logic rstn;
    logic enable;
    logic frame_start;
    logic frame_done;
    logic wr_buf;
    logic rd_buf;

    vp_fb_writer_if #(.DW(DW), .AW(AW)) bus ();

    vp_fb_writer #(
        .DW(DW), .RL(RL), .NL(NL), .AW(AW)
    ) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_enable      (enable),
        .i_frame_start (frame_start),
        .bus           (bus.master),
        .o_frame_done  (frame_done),
        .o_wr_buf      (wr_buf),
        .o_rd_buf      (rd_buf)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int last_tick  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the read tick; optionally check spacing to the last one.
    task automatic wait_tick(input string tag, input int gap_exp);
        int n = 0;
        while (bus.data_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_tick"}, 32'(bus.data_ready), 32'd1);
        if (gap_exp > 0) chk({tag, "_gap"}, 32'(cyc - last_tick), 32'(gap_exp));
        last_tick = cyc;
    endtask

    // One pixel: tick, latch, write (optionally stalled / with frame-start),
    // then check the idle cycle after acceptance.
    task automatic pixel(input string tag, input logic [DW-1:0] val,
                         input logic [AW-1:0] addr, input int stall,
                         input bit fs, input bit fd, input int gap);
        bus.data = val;
        wait_tick(tag, gap);
        step();                                     // LATCH
        chk({tag, "_rdy_single"}, 32'(bus.data_ready), 32'd0);
        if (stall > 0) bus.mem_ready = 1'b0;
        step();                                     // first WR cycle
        for (int i = 0; i < stall; i++) begin
            chk({tag, "_st_wr"},   32'(bus.mem_wr),     32'd1);
            chk({tag, "_st_addr"}, 32'(bus.mem_addr),   32'(addr));
            chk({tag, "_st_data"}, 32'(bus.mem_data),   32'(val));
            chk({tag, "_st_rdy"},  32'(bus.data_ready), 32'd0);
            step();
        end
        bus.mem_ready = 1'b1;
        if (fs) frame_start = 1'b1;
        chk({tag, "_wr"},   32'(bus.mem_wr),   32'd1);
        chk({tag, "_addr"}, 32'(bus.mem_addr), 32'(addr));
        chk({tag, "_data"}, 32'(bus.mem_data), 32'(val));
        step();                                     // IDLE after acceptance
        frame_start = 1'b0;
        chk({tag, "_wr_off"}, 32'(bus.mem_wr),  32'd0);
        chk({tag, "_fdone"},  32'(frame_done),  32'(fd));
    endtask

    initial begin
        rstn           = 1'b0;
        enable         = 1'b1;
        frame_start    = 1'b0;
        bus.data_valid = 1'b1;
        bus.mem_ready  = 1'b1;
        bus.data       = '0;

        // Reset held 3 cycles with valid high: everything stays quiet.
        repeat (3) begin
            step();
            chk("rst_rdy",   32'(bus.data_ready), 32'd0);
            chk("rst_wr",    32'(bus.mem_wr),     32'd0);
            chk("rst_addr",  32'(bus.mem_addr),   32'd0);
            chk("rst_data",  32'(bus.mem_data),   32'd0);
            chk("rst_fdone", 32'(frame_done),     32'd0);
            chk("rst_wrbuf", 32'(wr_buf),         32'd0);
            chk("rst_rdbuf", 32'(rd_buf),         32'd0);
        end
        rstn = 1'b1;

        // Frame 1: streaming, ticks 4 cycles apart, frame done after pixel 8.
        for (int i = 0; i < 8; i++) begin
            pixel($sformatf("stream%0d", i), 12'(i + 1), 5'(i), 0, 1'b0,
                  (i == 7), (i == 0) ? 0 : 4);
            $display("stream pixel %0d addr %0d data 0x%0h", i, i, i + 1);
        end
        chk("f1_wrbuf", 32'(wr_buf), 32'(DB));
        chk("f1_rdbuf", 32'(rd_buf), 32'd0);
        step();
        chk("f1_fdone_pulse", 32'(frame_done), 32'd0);

        // Memory backpressure: 5 stalled cycles, then the next address.
        pixel("bp", 12'h123, B2, 5, 1'b0, 1'b0, 0);
        $display("backpressure pixel addr %0d data 0x123", B2);
        pixel("bp_next", 12'h124, B2 + 5'd1, 0, 1'b0, 1'b0, 0);
        $display("post-stall pixel addr %0d data 0x124", B2 + 5'd1);

        // Frame-start during the write of address 2: it still completes,
        // one realign cycle follows, then the frame restarts at the base.
        pixel("fs", 12'h200, B2 + 5'd2, 0, 1'b1, 1'b0, 0);
        $display("frame-start pixel addr %0d data 0x200", B2 + 5'd2);
        pixel("realign", 12'h201, B2, 0, 1'b0, 1'b0, 5);
        $display("realigned pixel addr %0d data 0x201", B2);
        for (int i = 1; i < 8; i++) begin
            pixel($sformatf("f2_%0d", i), 12'(12'h201 + i), B2 + 5'(i), 0, 1'b0,
                  (i == 7), 4);
            $display("frame2 pixel addr %0d data 0x%0h", B2 + 5'(i), 12'h201 + i);
        end
        chk("f2_wrbuf", 32'(wr_buf), 32'd0);
        chk("f2_rdbuf", 32'(rd_buf), 32'(DB));

        // Enable low: no fetches even though data is available.
        enable = 1'b0;
        repeat (6) begin
            step();
            chk("dis_rdy",   32'(bus.data_ready), 32'd0);
            chk("dis_fdone", 32'(frame_done),     32'd0);
        end
        enable = 1'b1;
        $display("enable-low window idle");

        // Reset in LATCH aborts the pixel; next frame starts at address 0.
        pixel("pre_rst", 12'h3A0, 5'd0, 0, 1'b0, 1'b0, 0);
        bus.data = 12'h3AA;
        wait_tick("rst_mid", 0);
        step();                                     // LATCH
        rstn = 1'b0;
        step();
        chk("rstmid_wr",   32'(bus.mem_wr),     32'd0);
        chk("rstmid_addr", 32'(bus.mem_addr),   32'd0);
        chk("rstmid_data", 32'(bus.mem_data),   32'd0);
        chk("rstmid_rdy",  32'(bus.data_ready), 32'd0);
        rstn = 1'b1;
        pixel("post_rst", 12'h3AB, 5'd0, 0, 1'b0, 1'b0, 0);
        $display("mid-transaction reset, next pixel addr 0 data 0x3ab");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
